mem_lsu: RTL
============

# mem_lsu

Memory-stage load/store unit: the consumer side of the EX/MEM pipeline register. It takes the registered EX results, passes ALU results straight through to the MEM/WB register, and runs the data-bus transaction for loads and stores. While a transaction is outstanding it raises a stall request to the pipeline controller. Loads are sign- or zero-extended before write-back.

## Interface
Parameters:
- `WAIT_MAX`, default 255: maximum number of BUSY cycles before a bus timeout.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset (`RSTENABLE` = 1).
- `mem_wd` in 5: destination register from EX/MEM.
- `mem_wreg` in 1: write enable from EX/MEM.
- `mem_wdata` in 32: ALU result from EX/MEM.
- `mem_aluop` in 8: operation code from EX/MEM.
- `mem_addr` in 32: effective byte address.
- `mem_reg2` in 32: store data (rt).
- `wb_wd` out 5: destination register to MEM/WB.
- `wb_wreg` out 1: write enable to MEM/WB.
- `wb_wdata` out 32: write-back data to MEM/WB.
- `stallreq` out 1: stall request to the pipeline controller.
- `dbus_req` out 1: bus request; held until ack or timeout.
- `dbus_we` out 1: 1 = store.
- `dbus_addr` out 32: word-aligned address, `{mem_addr[31:2],2'b00}`.
- `dbus_sel` out 4: byte enables, where bit 3 is byte `[31:24]`.
- `dbus_wdata` out 32: store data replicated across byte lanes.
- `dbus_rdata` in 32: read data; valid only in the ack cycle.
- `dbus_ack` in 1: one-cycle completion.
- `bus_err` out 1: one-cycle pulse on timeout.
- `exc_adel` out 1, `exc_ades` out 1: address-error pulses. These ports exist only with `MEM_ADDR_EXC_EN`.

## Operation
- Supported ops: LB, LBU, LH, LHU, LW, SB, SH, SW. Any other op is non-memory.
- **States:** IDLE, BUSY, DONE.
- **IDLE, non-memory op:**
  - Combinational pass-through: `wb_* = mem_*`.
  - `stallreq` = 0.
- **IDLE, memory op:**
  - `stallreq` = 1 combinationally.
  - Latch addr, sel, we, wdata and op.
  - Next state BUSY.
- **BUSY:**
  - `dbus_req` = 1 and `stallreq` = 1.
  - The wait counter increments each cycle.
  - On `dbus_ack`: capture the extended read data into the result register and go to DONE.
  - If the counter reaches `WAIT_MAX` with no ack: deassert `dbus_req`, pulse `bus_err` in the following DONE cycle, and go to DONE.
- **DONE:**
  - `stallreq` = 0, so MEM/WB captures at the end of this cycle.
  - `wb_wd = mem_wd`.
  - Load: `wb_wreg` = 1 and `wb_wdata` = result.
  - Store, timeout or exception: `wb_wreg` = 0.
  - Next state IDLE.
- **Byte lanes (big-endian), keyed on `addr[1:0]`:**
  - Byte access: sel = 1000 / 0100 / 0010 / 0001.
  - Halfword access: `addr[1]`=0 gives 1100; `addr[1]`=1 gives 0011.
  - Word access: sel = 1111.
- **Store data:**
  - SB: `{4{reg2[7:0]}}`.
  - SH: `{2{reg2[15:0]}}`.
  - SW: `reg2`.
- **Load extension:**
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
- **Boundary rules:**
  - `dbus_ack` outside BUSY is ignored.
  - Ack in the same cycle the counter reaches `WAIT_MAX`: ack wins and there is no `bus_err`.
  - `dbus_rdata` is sampled only in the ack cycle.
- **Reset (any state, including mid-BUSY):**
  - Next edge: state IDLE and counter 0.
  - `dbus_req`, `dbus_we`, `dbus_sel`, `dbus_addr`, `dbus_wdata`, `bus_err`, `exc_*` all 0.
  - While `rst` = 1: `wb_wd` = `NOPREGADDR`, `wb_wreg` = 0, `wb_wdata` = 0, `stallreq` = 0.

## Timing
- Non-memory op: 0 added latency, no stall.
- Memory op with ack in the k-th BUSY cycle: occupies the MEM stage for k+2 cycles, with `stallreq` high for k+1 cycles. A zero-wait bus (k=1) gives 3 cycles.
- `dbus_*` outputs are registered. They are stable from the first BUSY cycle through the ack cycle.
- The pipeline controller holds EX/MEM while `stallreq` = 1. The `mem_*` inputs are therefore constant from IDLE through DONE.

## Configuration
- **With `MEM_ADDR_EXC_EN` defined:** misaligned accesses skip BUSY and go IDLE→DONE with `wb_wreg` = 0. The exception pulse is asserted in DONE.
  - `exc_adel` is raised for loads: LH/LHU with `addr[0]`=1, or LW with `addr[1:0]`≠0.
  - `exc_ades` is raised for SH/SW under the same address conditions.
- **Without `MEM_ADDR_EXC_EN`:** the `exc_*` ports are absent. Halfword accesses ignore `addr[0]` and word accesses ignore `addr[1:0]`.

## Structure
- `defines.v` holds:
  - the op codes (`EXE_LB_OP` … `EXE_SW_OP`);
  - `RSTENABLE`, `NOPREGADDR`, `ZEROWORD`;
  - the state encodings `LSU_IDLE/BUSY/DONE`.
- One sub-module, `lsu_lane`: combinational sel/wdata generation and load extraction/extension from op and `addr[1:0]`.

## Test plan
- **ALU pass-through:** ADD result 0x1234 to r5 → same-cycle `wb_wd`=5, `wb_wreg`=1, `wb_wdata`=0x1234, `stallreq`=0.
- **LB, zero wait:** LB at 0x103, rdata 0x000000F0, ack in 1st BUSY cycle → `dbus_addr`=0x100, sel=0001, DONE `wb_wdata`=0xFFFFFFF0, 3 cycles total, stallreq high for 2.
- **SH, 3 waits:** SH at 0x202, reg2=0xABCD1234, ack in 4th BUSY cycle → sel=0011, wdata=0x12341234, we=1, `wb_wreg`=0, stall 5 cycles.
- **Timeout:** `WAIT_MAX`=4, no ack → req drops after 4 BUSY cycles, `bus_err` pulses once in DONE, `wb_wreg`=0. Ack on the 4th cycle instead → no `bus_err`.
- **Reset mid-BUSY:** `rst`=1 in 2nd BUSY cycle → next edge `dbus_req`=0 and state IDLE. A late ack afterwards is ignored.
- **`MEM_ADDR_EXC_EN`:** LW at 0x301 → no `dbus_req`, `exc_adel` 1-cycle pulse, `wb_wreg`=0. SW at 0x302 → `exc_ades`.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// mem_lsu_pkg : shared op codes, reset constants and LSU state encodings
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_lsu_pkg;

  localparam logic       RSTENABLE  = 1'b1;
  localparam logic [4:0] NOPREGADDR = 5'b00000;
  localparam logic [31:0] ZEROWORD  = 32'h0000_0000;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_BUSY = 2'd1;
  localparam logic [1:0] LSU_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = LSU_IDLE,
    ST_BUSY = LSU_BUSY,
    ST_DONE = LSU_DONE
  } lsu_state_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_lane.sv
// ============================================================================
// mem_lsu_lane : big-endian byte-lane select, store replication, load extend
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_sel_b;
  logic [3:0]  w_sel_h;

  always_comb begin
    // byte address 0 lives in bits [31:24]
    case (addr_lo)
      2'd0:    w_byte = rdata[31:24];
      2'd1:    w_byte = rdata[23:16];
      2'd2:    w_byte = rdata[15:8];
      default: w_byte = rdata[7:0];
    endcase
    w_half  = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    w_sel_b = 4'b1000 >> addr_lo;
    w_sel_h = addr_lo[1] ? 4'b0011 : 4'b1100;

    sel       = 4'b0000;
    wdata     = reg2;
    load_data = ZEROWORD;
    case (op)
      EXE_LB_OP:  begin sel = w_sel_b; load_data = {{24{w_byte[7]}}, w_byte}; end
      EXE_LBU_OP: begin sel = w_sel_b; load_data = {24'h0, w_byte}; end
      EXE_LH_OP:  begin sel = w_sel_h; load_data = {{16{w_half[15]}}, w_half}; end
      EXE_LHU_OP: begin sel = w_sel_h; load_data = {16'h0, w_half}; end
      EXE_LW_OP:  begin sel = 4'b1111; load_data = rdata; end
      EXE_SB_OP:  begin sel = w_sel_b; wdata = {4{reg2[7:0]}}; end
      EXE_SH_OP:  begin sel = w_sel_h; wdata = {2{reg2[15:0]}}; end
      EXE_SW_OP:  begin sel = 4'b1111; wdata = reg2; end
      default:    ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// mem_lsu : MEM-stage load/store unit with data-bus FSM and stall request.
//           Optional misaligned-address exceptions via MEM_ADDR_EXC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        bus_err
`ifdef MEM_ADDR_EXC_EN
  ,
  output logic        exc_adel,
  output logic        exc_ades
`endif
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  lsu_state_t    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_op;
  logic [1:0]    r_addr_lo;
  logic [31:0]   r_result;
  logic          r_req, r_we, r_err, r_exc_l, r_exc_s;
  logic [3:0]    r_sel;
  logic [31:0]   r_addr, r_wdata;

  logic [7:0]    w_op;
  logic [1:0]    w_lo;
  logic [3:0]    w_sel;
  logic [31:0]   w_wdata, w_load_data;
  logic          w_is_mem, w_mis_ld, w_mis_st, w_ack, w_timeout;

  // IDLE decodes the live EX/MEM op; later states use the latched copy
  assign w_op     = (r_state == ST_IDLE) ? mem_aluop : r_op;
  assign w_lo     = (r_state == ST_IDLE) ? mem_addr[1:0] : r_addr_lo;
  assign w_is_mem = is_load(mem_aluop) || is_store(mem_aluop);

`ifdef MEM_ADDR_EXC_EN
  logic w_mis_h, w_mis_w;
  assign w_mis_h  = mem_addr[0];
  assign w_mis_w  = (mem_addr[1:0] != 2'b00);
  assign w_mis_ld = ((mem_aluop == EXE_LH_OP || mem_aluop == EXE_LHU_OP) && w_mis_h) ||
                    ((mem_aluop == EXE_LW_OP) && w_mis_w);
  assign w_mis_st = ((mem_aluop == EXE_SH_OP) && w_mis_h) ||
                    ((mem_aluop == EXE_SW_OP) && w_mis_w);
  assign exc_adel = r_exc_l;
  assign exc_ades = r_exc_s;
`else
  assign w_mis_ld = 1'b0;
  assign w_mis_st = 1'b0;
`endif

  // ack wins over a timeout landing in the same cycle
  assign w_ack     = (r_state == ST_BUSY) && dbus_ack;
  assign w_timeout = (r_state == ST_BUSY) && !dbus_ack && (r_cnt == CW'(WAIT_MAX - 1));

  mem_lsu_lane u_lane (
    .op        (w_op),
    .addr_lo   (w_lo),
    .reg2      (mem_reg2),
    .rdata     (dbus_rdata),
    .sel       (w_sel),
    .wdata     (w_wdata),
    .load_data (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= 8'h00;
      r_addr_lo <= 2'b00;
      r_result  <= ZEROWORD;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= 4'b0000;
      r_addr    <= ZEROWORD;
      r_wdata   <= ZEROWORD;
      r_err     <= 1'b0;
      r_exc_l   <= 1'b0;
      r_exc_s   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_timeout;
      r_exc_l <= 1'b0;
      r_exc_s <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_is_mem) begin
            r_op      <= mem_aluop;
            r_addr_lo <= mem_addr[1:0];
            r_addr    <= {mem_addr[31:2], 2'b00};
            r_sel     <= w_sel;
            r_we      <= is_store(mem_aluop);
            r_wdata   <= w_wdata;
            r_cnt     <= '0;
            r_req     <= !(w_mis_ld || w_mis_st);
            r_exc_l   <= w_mis_ld;
            r_exc_s   <= w_mis_st;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_ack) begin
            r_result <= w_load_data;
            r_req    <= 1'b0;
          end else if (w_timeout) begin
            r_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    wb_wd    = mem_wd;
    wb_wreg  = 1'b0;
    wb_wdata = ZEROWORD;
    stallreq = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mem) begin
          stallreq = 1'b1;
          w_next   = (w_mis_ld || w_mis_st) ? ST_DONE : ST_BUSY;
        end else begin
          wb_wreg  = mem_wreg;
          wb_wdata = mem_wdata;
        end
      end
      ST_BUSY: begin
        stallreq = 1'b1;
        if (w_ack || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
        if (is_load(r_op) && !r_err && !r_exc_l) begin
          wb_wreg  = 1'b1;
          wb_wdata = r_result;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (rst == RSTENABLE) begin
      wb_wd    = NOPREGADDR;
      wb_wreg  = 1'b0;
      wb_wdata = ZEROWORD;
      stallreq = 1'b0;
    end
  end

  assign dbus_req   = r_req;
  assign dbus_we    = r_we;
  assign dbus_addr  = r_addr;
  assign dbus_sel   = r_sel;
  assign dbus_wdata = r_wdata;
  assign bus_err    = r_err;

endmodule

`default_nettype wire
